// File: rtl/msrv32_store_buffer.sv
// Posted-write store buffer: FIFO of word-aligned stores drained over a valid/ready bus,
// with load-hit detection. Define MSRV32_STORE_MERGE_EN to merge same-word stores into the newest entry.
module msrv32_store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_n_in,
  input  logic               st_req_in,
  input  logic [WIDTH-1:0]   st_addr_in,
  input  logic [WIDTH-1:0]   st_data_in,
  input  logic [3:0]         st_mask_in,
  output logic               st_stall_out,
  input  logic               ld_req_in,
  input  logic [WIDTH-1:0]   ld_addr_in,
  output logic               ld_hazard_out,
  output logic               bus_valid_out,
  output logic [WIDTH-1:0]   bus_addr_out,
  output logic [WIDTH-1:0]   bus_data_out,
  output logic [3:0]         bus_mask_out,
  input  logic               bus_ready_in,
  output logic               empty_out,
  output logic [PTR_W:0]     count_out
);

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] addr_d [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [3:0]       mask_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full;
  logic merge_hit;
  logic do_push;
  logic do_pop;
  logic hazard;
  logic [PTR_W-1:0] idx;

  assign full = (count_q == (PTR_W+1)'(DEPTH));

`ifdef MSRV32_STORE_MERGE_EN
  logic [PTR_W-1:0] newest;
  assign newest = wr_ptr_q - PTR_W'(1);
  // Only merge when the newest entry is not the head, so a beat in flight is never modified.
  assign merge_hit = st_req_in && (count_q >= (PTR_W+1)'(2)) &&
                     (((addr_q[newest] ^ st_addr_in) >> 2) == '0);
`else
  assign merge_hit = 1'b0;
`endif

  assign do_push = st_req_in && !full && !merge_hit;
  assign do_pop  = (count_q != '0) && bus_ready_in;

  assign st_stall_out  = st_req_in && full && !merge_hit;
  assign bus_valid_out = (count_q != '0);
  assign bus_addr_out  = addr_q[rd_ptr_q];
  assign bus_data_out  = data_q[rd_ptr_q];
  assign bus_mask_out  = mask_q[rd_ptr_q];
  assign empty_out     = (count_q == '0);
  assign count_out     = count_q;

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
`ifdef MSRV32_STORE_MERGE_EN
    if (merge_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask_in[b]) data_d[newest][8*b +: 8] = st_data_in[8*b +: 8];
      end
      mask_d[newest] = mask_q[newest] | st_mask_in;
    end
`endif
    if (do_push) begin
      addr_d[wr_ptr_q] = st_addr_in;
      data_d[wr_ptr_q] = st_data_in;
      mask_d[wr_ptr_q] = st_mask_in;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  // Live entries are the count_q slots starting at the head, wrapping around.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (((addr_q[idx] ^ ld_addr_in) >> 2) == '0))
        hazard = 1'b1;
    end
    ld_hazard_out = ld_req_in && hazard;
  end

  // NOTE: the storage array is reset too, so the bus payload reads as zero straight out of reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/msrv32_store_buffer.md
Name: msrv32_store_buffer

Overview:
- Posted-write buffer directly downstream of the store unit.
- Captures word-aligned store requests (address, data, byte mask) into a small FIFO and drains them to the data-memory bus over a valid/ready handshake.
- Stalls the pipeline only when full.
- Flags loads that hit a pending store so the core can hold them until the store drains.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH, 4, buffer entries; power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- ms_riscv32_mp_clk_in  input  1  clock; all state on rising edge.
- ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous assert, active-low.
- st_req_in  input  1  store request from store unit.
- st_addr_in  input  WIDTH  store address, word-aligned, bits[1:0]=0.
- st_data_in  input  WIDTH  lane-positioned store data.
- st_mask_in  input  4  byte-lane write mask.
- st_stall_out  output  1  store not accepted this cycle; pipeline holds and re-presents.
- ld_req_in  input  1  load in progress.
- ld_addr_in  input  WIDTH  load address.
- ld_hazard_out  output  1  load word matches a buffered store.
- bus_valid_out  output  1  head entry presented to memory.
- bus_addr_out  output  WIDTH  head address.
- bus_data_out  output  WIDTH  head data.
- bus_mask_out  output  4  head byte mask.
- bus_ready_in  input  1  memory accepts the presented entry.
- empty_out  output  1  no entries pending; used by FENCE.
- count_out  output  PTR_W+1  occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Every storage entry's addr, data and mask cleared to 0.
  - Therefore: bus_valid_out=0, bus_addr/data/mask_out=0, empty_out=1, count_out=0, st_stall_out=0, ld_hazard_out=0.
  - Reset mid-drain discards all entries; no bus transaction completes afterwards.
- Push: when st_req_in=1 and count<DEPTH, on the clock edge:
  - Write {st_addr_in, st_data_in, st_mask_in} at wr_ptr.
  - wr_ptr increments, wrapping modulo DEPTH.
  - Push with st_mask_in=0 is still accepted and issued.
- Stall:
  - st_stall_out = st_req_in && (count==DEPTH). Combinational.
  - Does not consider a same-cycle pop.
  - A stalled request is not written.
- Pop / bus handshake:
  - bus_valid_out = (count!=0). Payload outputs come straight from the entry at rd_ptr.
  - Transfer occurs on an edge where bus_valid_out && bus_ready_in; rd_ptr then increments, wrapping.
  - While valid and not ready, the payload holds stable.
  - bus_ready_in is ignored when count=0.
- Simultaneous push+pop:
  - count unchanged; both pointers advance.
  - With count=1, the new entry becomes head on the next cycle.
  - Minimum latency from push to bus_valid_out is 1 cycle (entry visible the cycle after the push edge).
- Ordering: strict FIFO; stores reach memory in program order.
- Load hazard:
  - ld_hazard_out = ld_req_in && any valid entry has addr[WIDTH-1:2] == ld_addr_in[WIDTH-1:2]. Combinational.
  - Valid entries are the count entries starting at rd_ptr, with wrap.
  - The head entry still counts during its transfer cycle.
- count_out/empty_out are registered-state derived; empty_out = (count==0).

Optional Feature:
- Macro: MSRV32_STORE_MERGE_EN.
- Defined: a push merges into the newest entry (wr_ptr-1) instead of allocating, when all of the following hold:
  - count>=2, so the newest entry is not the head.
  - Word addresses are equal.
  - Merge rules:
    - For each lane with st_mask_in bit set, that data byte is overwritten.
    - Entry mask becomes the OR of the old and new masks.
    - wr_ptr and count are unchanged.
    - The merge is accepted even when full, so st_stall_out=0 for a merging push.
- Not defined: no merging; every accepted push allocates an entry.

Test Plan:
- Reset then idle:
  - rst_n=0 mid-run with 3 entries -> immediately bus_valid_out=0, count_out=0, empty_out=1, bus outputs 0.
  - After release, no bus activity.
- Single store, ready high:
  - st_req with addr 0x100, data 0x000000AB, mask 0001 -> next cycle bus_valid=1 with that payload; following edge count=0, empty_out=1.
- Fill and stall:
  - bus_ready=0, 5 consecutive stores to 0x0,0x4,0x8,0xC,0x10 -> count_out=4.
  - 5th cycle st_stall_out=1; 0x10 not stored.
  - Raise ready -> drains 0x0,0x4,0x8,0xC in order, one per cycle.
- Simultaneous push/pop at count=1:
  - Head 0x20 transferring while pushing 0x24 -> count stays 1, next head 0x24.
  - Pointer wrap verified after 9 total pushes.
- Load hazard:
  - Buffered store at 0x40 held (ready=0).
  - ld_req with ld_addr 0x43 -> ld_hazard_out=1.
  - ld_addr 0x44 -> 0.
  - After drain, 0x43 -> 0.
- Merge (macro defined):
  - ready=0, stores: 0x0 mask0001 data 0x11, then 0x8 mask0001 0x22, then 0x8 mask0100 data 0x00330000 -> count=2.
  - Entry 1 data 0x00330022, mask 0101.
  - Without macro: count=3.
